// File: rtl/serial_pkg.sv
// serial_pkg: shared constants, types and helpers for the serial payload path.
package serial_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 2;
  localparam int unsigned DROP_CNT_W     = 8;

  // What happens to a word on the cycle it completes.
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_PUSH   = 2'd1,
    EV_DROP   = 2'd2,
    EV_REJECT = 2'd3
  } word_event_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/payload_fifo.sv
// payload_fifo: small synchronous FIFO; an occupancy count separates full from empty.
// A push while full is legal when a pop happens on the same edge.
module payload_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_pop;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Pointer, count and storage update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    // When full, the write slot equals the head slot; the head leaves on the
    // same edge, so overwriting it is safe.
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serial_payload_receiver.sv
// serial_payload_receiver: assembles DATA_W serial payload bits per detector
// window into words, buffers them and offers them via valid/ready.
// Optional even-parity rejection is built when PAR_CHECK_EN is defined.
module serial_payload_receiver
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ser_data,
  input  logic                  frame_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  abort,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef PAR_CHECK_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  abort_q, abort_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  complete;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  word_event_e           word_ev;
`ifdef PAR_CHECK_EN
  logic                  parity_err_q, parity_err_d;
`endif

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign abort     = abort_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
`ifdef PAR_CHECK_EN
  assign parity_err = parity_err_q;
`endif

  // Shift path, bit counter and partial-frame abort detection.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    complete  = 1'b0;
    abort_d   = 1'b0;
    if (frame_valid) begin
      if (MSB_FIRST) begin
        shift_d = {shift_q[DATA_W-2:0], ser_data};
      end else begin
        shift_d = {ser_data, shift_q[DATA_W-1:1]};
      end
      if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
        complete  = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else if (bit_cnt_q != '0) begin
      abort_d   = 1'b1;
      bit_cnt_d = '0;
      shift_d   = '0;
    end
  end

  // Decide the fate of a completed word and update the event flags.
  // shift_d already contains the bit sampled on the completing cycle.
  always_comb begin
    word_ev = EV_NONE;
    if (complete) begin
`ifdef PAR_CHECK_EN
      if (^shift_d) begin
        word_ev = EV_REJECT;
      end else if (!fifo_full || pop) begin
        word_ev = EV_PUSH;
      end else begin
        word_ev = EV_DROP;
      end
`else
      if (!fifo_full || pop) begin
        word_ev = EV_PUSH;
      end else begin
        word_ev = EV_DROP;
      end
`endif
    end
    push       = (word_ev == EV_PUSH);
    overflow_d = (word_ev == EV_DROP);
    drop_cnt_d = overflow_d ? sat_inc(drop_cnt_q) : drop_cnt_q;
`ifdef PAR_CHECK_EN
    parity_err_d = (word_ev == EV_REJECT);
`endif
  end

  // Assembly and event-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      abort_q      <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
`ifdef PAR_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      abort_q      <= abort_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
`ifdef PAR_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  payload_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .wdata(shift_d),
    .rdata(out_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_serial_payload_receiver.sv
// tb_serial_payload_receiver: randomized and directed stimulus, frame-level
// reference model feeding a scoreboard, monitor comparing on the falling edge.
module tb_serial_payload_receiver;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam bit          MSB_FIRST  = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ser_data = 1'b0;
  logic              frame_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              abort;
  logic              overflow;
  logic [7:0]        drop_cnt;
`ifdef PAR_CHECK_EN
  logic              parity_err;
`endif

  int errors = 0;
  int checks = 0;
  bit rand_ready = 1'b0;

  serial_payload_receiver #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MSB_FIRST (MSB_FIRST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_data   (ser_data),
    .frame_valid(frame_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .abort      (abort),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
`ifdef PAR_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: bits of the current frame, model FIFO contents,
  // scoreboard of words the consumer should see, and expected flags.
  bit                bitq [$];
  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] m_word, m_tmp, exp_head;
  bit                m_pop, m_done, m_ok, m_room;
  bit                exp_valid = 0, exp_abort = 0, exp_over = 0, exp_par = 0;
  int                exp_drop = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Frame-level model evaluated on each clock edge from the DUT inputs only.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitq.delete();
      mq.delete();
      sb.delete();
      exp_valid = 0; exp_abort = 0; exp_over = 0; exp_par = 0; exp_drop = 0;
      exp_head  = '0;
    end else begin
      m_pop  = (mq.size() != 0) && out_ready;
      m_done = 0;
      exp_abort = 0; exp_over = 0; exp_par = 0;
      if (frame_valid) begin
        bitq.push_back(ser_data);
        if (bitq.size() == DATA_W) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (MSB_FIRST) m_word[DATA_W-1-i] = bitq[i];
            else           m_word[i]          = bitq[i];
          end
          bitq.delete();
          m_done = 1;
        end
      end else if (bitq.size() != 0) begin
        exp_abort = 1;
        bitq.delete();
      end
      m_ok = 1;
`ifdef PAR_CHECK_EN
      m_ok = ~^m_word;
`endif
      if (m_done && !m_ok) exp_par = 1;
      m_room = (mq.size() < FIFO_DEPTH) || m_pop;
      if (m_pop) m_tmp = mq.pop_front();
      if (m_done && m_ok) begin
        if (m_room) begin
          mq.push_back(m_word);
          sb.push_back(m_word);
        end else begin
          exp_over = 1;
          if (exp_drop < 255) exp_drop++;
        end
      end
      exp_valid = (mq.size() != 0);
      if (exp_valid) exp_head = mq[0];
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("abort",     {31'd0, abort},     {31'd0, exp_abort});
    chk("overflow",  {31'd0, overflow},  {31'd0, exp_over});
    chk("drop_cnt",  {24'd0, drop_cnt},  exp_drop[DATA_W-1:0]);
`ifdef PAR_CHECK_EN
    chk("parity_err", {31'd0, parity_err}, {31'd0, exp_par});
`endif
    if (!rst_n) begin
      chk("reset_out_data", out_data, '0);
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected at %0t: got word %h expected no word", $time, out_data);
      end else begin
        m_tmp = sb.pop_front();
        chk("sb_word", out_data, m_tmp);
      end
    end
  end

  task automatic step(input logic fv, input logic b);
    frame_valid = fv;
    ser_data    = b;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w, input int n, input bit ready_last);
    for (int i = 0; i < n; i++) begin
      if (ready_last && i == n - 1) out_ready = 1'b1;
      step(1'b1, MSB_FIRST ? w[DATA_W-1-i] : w[i]);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single frame.
    out_ready = 1'b1;
    send_frame(32'hA5A5_0F0F, DATA_W, 0);
    idle(3);

    // Abort after 10 bits, then a clean frame.
    send_frame(32'h1234_5678, 10, 0);
    idle(2);
    send_frame(32'h0F0F_3C3C, DATA_W, 0);
    idle(3);

    // Back-to-back frames.
    send_frame(32'h0000_0001, DATA_W, 0);
    send_frame(32'hFFFF_FFFF, DATA_W, 0);
    idle(3);

    // Overflow with the consumer stalled, then drain.
    out_ready = 1'b0;
    send_frame(32'h1111_1111, DATA_W, 0);
    send_frame(32'h2222_2222, DATA_W, 0);
    send_frame(32'h3333_3333, DATA_W, 0);
    idle(2);
    out_ready = 1'b1;
    idle(4);

    // Full FIFO with a pop on the completion edge of the third frame.
    out_ready = 1'b0;
    send_frame(32'h4444_4444, DATA_W, 0);
    send_frame(32'h5555_5555, DATA_W, 0);
    idle(1);
    send_frame(32'h6666_6666, DATA_W, 1);
    idle(4);

    // Drop counter saturation.
    out_ready = 1'b0;
    for (int i = 0; i < 260; i++) send_frame($urandom, DATA_W, 0);
    out_ready = 1'b1;
    idle(4);

    // Asynchronous reset mid-frame with buffered words.
    out_ready = 1'b0;
    send_frame(32'hDEAD_BEEF, DATA_W, 0);
    send_frame(32'hCAFE_F00D, 15, 0);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_frame(32'h0BAD_CAFE, DATA_W, 0);
    idle(3);

    // Randomized traffic with random backpressure and aborts.
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      if ($urandom_range(0, 7) == 0) send_frame(w, $urandom_range(1, DATA_W - 1), 0);
      else                           send_frame(w, DATA_W, 0);
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle(6);

    chk("sb_drained", sb.size(), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_payload_receiver.md
# serial_payload_receiver

Downstream stage of the serial header detector. While the detector's frame-valid output is high, this block samples the serial line once per cycle and assembles DATA_W payload bits into a word. Completed words go into a small FIFO and are offered to the system through a valid/ready handshake. It also reports partial-frame aborts and FIFO overflow.

## Interface
- DATA_W, 32, payload bits per frame; must equal the detector's valid-window length.
- FIFO_DEPTH, 2, output buffer entries; power of two, at least 2.
- MSB_FIRST, 1, 1 = first sampled bit lands in bit DATA_W-1; 0 = first bit lands in bit 0.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ser_data  in  1  serial line, same signal the detector watches.
- frame_valid  in  1  detector window; high for exactly the payload cycles.
- out_data  out  DATA_W  head-of-FIFO word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- abort  out  1  one-cycle pulse: frame_valid fell with a partial word.
- overflow  out  1  one-cycle pulse: completed word dropped because the FIFO was full.
- drop_cnt  out  8  saturating count of overflow events.
- parity_err  out  1  present only with PAR_CHECK_EN; one-cycle pulse.

## Operation
- Shift path:
  - Each cycle with frame_valid=1: shift ser_data into the shift register in MSB_FIRST order; bit_cnt++.
  - bit_cnt is $clog2(DATA_W)+1 bits wide.
- Completion:
  - When the sampled bit is bit number DATA_W, the assembled word (including the bit sampled that cycle) is the push candidate.
  - bit_cnt returns to 0 at that edge.
  - If frame_valid stays high, the next bit starts a new word. Back-to-back frames cause no bubble.
- Abort:
  - frame_valid=0 with bit_cnt≠0: discard the partial word, clear bit_cnt, pulse abort for one cycle.
  - frame_valid=0 with bit_cnt=0: idle, no pulse.
- FIFO:
  - Push = completion and (not full, or pop in the same cycle).
  - Pop = out_valid && out_ready.
  - Simultaneous push and pop when full: both occur; occupancy unchanged.
  - Simultaneous push and pop when empty: the word enters; out_valid rises next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH. The count register disambiguates full from empty.
- Overflow:
  - Completion while full with no pop: word dropped, overflow pulses, drop_cnt increments.
  - drop_cnt saturates at 255.
- Handshake:
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop.

## Timing
- Reset values:
  - out_valid=0, out_data=0, abort=0, overflow=0, drop_cnt=0, parity_err=0.
  - FIFO empty, bit_cnt=0, shift register 0.
- Latency: out_valid is high the cycle after the edge that sampled the last payload bit, when the FIFO was empty.
- Throughput: one word per DATA_W cycles sustained; one pop per cycle.
- abort, overflow and parity_err are registered and asserted the cycle after the causing edge.
- Reset mid-frame or with the FIFO occupied: all state clears immediately (asynchronously); partial and buffered words are lost.

## Configuration
- PAR_CHECK_EN defined:
  - A completed word must have even parity over all DATA_W bits.
  - On failure: the word is not pushed, parity_err pulses, and overflow is not asserted even if the FIFO is full.
- PAR_CHECK_EN undefined:
  - No parity logic and no parity_err port.
  - Every completed word is a push candidate.

## Structure
- Shared package serial_pkg:
  - DATA_W default constant.
  - FIFO_DEPTH default constant.
  - Width constant for drop_cnt (8).
- Sub-module payload_fifo:
  - Parameterised DATA_W/FIFO_DEPTH synchronous FIFO.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Same clk/rst_n.
- Top level holds the shift register, bit counter, abort/overflow/parity logic and drop_cnt.

## Test plan
- Single frame: frame_valid high 32 cycles with bits 0xA5A5_0F0F MSB-first, out_ready=1 -> out_valid for one cycle with out_data=0xA5A5_0F0F, one cycle after the last bit.
- Abort: frame_valid high 10 cycles then low -> abort pulses once; no push; the next full frame delivers correctly.
- Back-to-back: 64 cycles of frame_valid carrying 0x0000_0001 then 0xFFFF_FFFF -> two words in order, no bubble between completions.
- Overflow: out_ready=0, three frames -> FIFO holds the first two; the third is dropped; overflow pulses; drop_cnt=1. Then out_ready=1 -> first two words pop in order.
- Full push+pop: FIFO full, out_ready=1 on the completion cycle of a third frame -> no overflow; all three words delivered.
- PAR_CHECK_EN: frame 0x0000_0001 (odd parity) -> parity_err pulse, no out_valid. Frame 0x0000_0003 -> delivered.
